// File: rtl/mem_arb_if.sv
// Bundle between mem_arb and its two requesters plus the shared memory bus.
// slave = arbiter side, master = requesters / memory side.
interface mem_arb_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          p0_req;
  logic          p1_req;
  logic          p0_we;
  logic          p1_we;
  logic [AW-1:0] p0_addr;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p1_wdata;
  logic          p1_lock;

  logic          p0_gnt;
  logic          p1_gnt;
  logic          p0_rvalid;
  logic          p1_rvalid;
  logic [DW-1:0] p0_rdata;
  logic [DW-1:0] p1_rdata;
  logic          p0_err;
  logic          p1_err;
  logic          busy;

  logic [AW-1:0] mem_addr;
  logic          mem_rw;
  logic [DW-1:0] mem_wdata;
  logic          mem_wdata_oe;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p1_lock, mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, busy, mem_addr, mem_rw, mem_wdata, mem_wdata_oe
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p1_lock, mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, busy, mem_addr, mem_rw, mem_wdata, mem_wdata_oe
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port arbiter for the byte-wide memory bus: fixed ACCESS/RESP sequence,
// round-robin with a capped p1 burst lock; the only block that drives mem_rw low.
module mem_arb #(
  parameter logic [3:0]  RAM_PAGE = 4'h0,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic       ph2,
  input  logic       reset,
  mem_arb_if.slave   bus
);
  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 8;
  localparam int unsigned LOCK_W = 4;
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              own_we;
  logic              own_legal;
  logic [LOCK_W-1:0] lock_cnt;

  logic              any_req;
  logic              lock_hold;
  logic              win_p1;
  logic              win_we;
  logic              win_legal;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;

  // Winner selection, only consumed at an evaluation edge (closing IDLE/RESP)
  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    lock_hold = last_owner & bus.p1_lock & bus.p1_req
              & ~(bus.p0_req & (lock_cnt == LOCK_LIM));
    win_p1    = bus.p1_req;
    if (lock_hold)
      win_p1 = 1'b1;
    else if (bus.p0_req & bus.p1_req)
      win_p1 = ~last_owner;
    win_we    = win_p1 ? bus.p1_we    : bus.p0_we;
    win_addr  = win_p1 ? bus.p1_addr  : bus.p0_addr;
    win_wdata = win_p1 ? bus.p1_wdata : bus.p0_wdata;
    win_legal = win_we & (win_addr[AW-1 -: 4] == RAM_PAGE);
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last_owner       <= 1'b1;
      own_we           <= 1'b0;
      own_legal        <= 1'b0;
      lock_cnt         <= '0;
      bus.p0_gnt       <= 1'b0;
      bus.p1_gnt       <= 1'b0;
      bus.p0_rvalid    <= 1'b0;
      bus.p1_rvalid    <= 1'b0;
      bus.p0_rdata     <= '0;
      bus.p1_rdata     <= '0;
      bus.p0_err       <= 1'b0;
      bus.p1_err       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_rw       <= 1'b1;
      bus.mem_wdata    <= '0;
      bus.mem_wdata_oe <= 1'b0;
    end else begin
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      case (state)
        ACCESS: begin
          // Memory has sampled; turn the bus around and flag dropped writes
          state            <= RESP;
          bus.busy         <= 1'b1;
          bus.mem_rw       <= 1'b1;
          bus.mem_wdata_oe <= 1'b0;
          if (own_we && !own_legal) begin
            if (owner) bus.p1_err <= 1'b1;
            else       bus.p0_err <= 1'b1;
          end
        end
        default: begin
          if (state == RESP && !own_we) begin
            if (owner) begin
              bus.p1_rdata  <= bus.mem_rdata;
              bus.p1_rvalid <= 1'b1;
            end else begin
              bus.p0_rdata  <= bus.mem_rdata;
              bus.p0_rvalid <= 1'b1;
            end
          end
          if (any_req) begin
            state            <= ACCESS;
            bus.busy         <= 1'b1;
            owner            <= win_p1;
            last_owner       <= win_p1;
            own_we           <= win_we;
            own_legal        <= win_legal;
            bus.mem_addr     <= win_addr;
            bus.mem_rw       <= ~win_legal;
            bus.mem_wdata_oe <= win_legal;
            if (win_legal) bus.mem_wdata <= win_wdata;
            if (win_p1) begin
              bus.p1_gnt <= 1'b1;
              lock_cnt   <= (lock_cnt == LOCK_LIM) ? lock_cnt : lock_cnt + LOCK_W'(1);
            end else begin
              bus.p0_gnt <= 1'b1;
              lock_cnt   <= '0;
            end
          end else begin
            state            <= IDLE;
            bus.busy         <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_rw       <= 1'b1;
            bus.mem_wdata_oe <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Randomized + directed bench for mem_arb against a transaction-level model
// (timestamped transactions, grant-run count, flat reference memory).
module tb_mem_arb;
  localparam logic [3:0]  RAM_PAGE = 4'h0;
  localparam int unsigned LOCK_MAX = 8;

  logic ph2   = 1'b0;
  logic reset = 1'b1;
  always #5 ph2 = ~ph2;

  mem_arb_if bus();

  mem_arb #(.RAM_PAGE(RAM_PAGE), .LOCK_MAX(LOCK_MAX)) dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'hF123) return 8'h3C;
    if (a[15:12] == RAM_PAGE || a[15:12] == 4'hF) return a[7:0] ^ 8'h5A;
    return 8'h00;
  endfunction

  // Memory on the bus: writes on every edge while mem_rw is low, registered read
  bit [7:0] mem [65536];
  bit       mem_wr [65536];
  always @(posedge ph2) begin
    if (!bus.mem_rw) begin
      mem[bus.mem_addr]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  bit [7:0]    rmem [65536];
  bit          rwr  [65536];
  int unsigned cyc = 0;
  bit          m_txn;
  int unsigned m_start;
  bit          m_owner, m_we, m_legal, m_last;
  logic [15:0] m_addr;
  logic [7:0]  m_rd;
  int unsigned m_run;
  bit          m_old_wr;
  bit [7:0]    m_old_val;

  bit [1:0]    e_gnt, e_rvalid, e_err;
  logic [7:0]  e_rdata [2];
  bit          e_busy, e_rw, e_oe, chk_addr;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;

  bit          prev_rw_low = 1'b0;
  int unsigned rw_low_cnt = 0;
  int unsigned err_cnt = 0;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return rwr[a] ? rmem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_txn = 1'b0; m_last = 1'b1; m_run = 0;
    e_gnt = '0; e_rvalid = '0; e_err = '0;
    e_rdata[0] = 8'h00; e_rdata[1] = 8'h00;
    e_busy = 1'b0; e_rw = 1'b1; e_oe = 1'b0; e_addr = 16'h0000; chk_addr = 1'b1;
    e_wdata = 8'h00;
  endtask

  // Predicts DUT outputs for the cycle following the next rising edge
  task automatic model_edge();
    bit w, r0, r1, we, legal;
    logic [15:0] a;
    logic [7:0]  d;
    cyc++;
    e_gnt = '0; e_rvalid = '0; e_err = '0;
    if (m_txn && cyc == m_start + 1) begin
      e_rw = 1'b1; e_oe = 1'b0; chk_addr = 1'b0; e_busy = 1'b1;
      if (m_we && !m_legal) e_err[m_owner] = 1'b1;
      return;
    end
    if (m_txn && !m_we) begin
      e_rvalid[m_owner] = 1'b1;
      e_rdata[m_owner]  = m_rd;
    end
    m_txn = 1'b0;
    r0 = bus.p0_req; r1 = bus.p1_req;
    chk_addr = 1'b1;
    if (!r0 && !r1) begin
      e_busy = 1'b0; e_rw = 1'b1; e_oe = 1'b0; e_addr = 16'h0000;
      return;
    end
    if (m_last && bus.p1_lock && r1 && !(r0 && m_run >= LOCK_MAX)) w = 1'b1;
    else if (r0 && r1) w = !m_last;
    else w = r1;
    m_run  = w ? m_run + 1 : 0;
    m_last = w;
    we = w ? bus.p1_we    : bus.p0_we;
    a  = w ? bus.p1_addr  : bus.p0_addr;
    d  = w ? bus.p1_wdata : bus.p0_wdata;
    legal = we && (a[15:12] == RAM_PAGE);
    m_old_wr = rwr[a]; m_old_val = rmem[a];
    if (legal) begin rmem[a] = d; rwr[a] = 1'b1; end
    m_rd = ref_rd(a);
    m_txn = 1'b1; m_start = cyc; m_owner = w; m_we = we; m_legal = legal; m_addr = a;
    e_gnt[w] = 1'b1; e_busy = 1'b1; e_rw = !legal; e_oe = legal; e_addr = a;
    if (legal) e_wdata = d;
  endtask

  task automatic compare_all();
    check("p0_gnt",    32'(bus.p0_gnt),    32'(e_gnt[0]));
    check("p1_gnt",    32'(bus.p1_gnt),    32'(e_gnt[1]));
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rvalid[0]));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rvalid[1]));
    check("p0_err",    32'(bus.p0_err),    32'(e_err[0]));
    check("p1_err",    32'(bus.p1_err),    32'(e_err[1]));
    check("p0_rdata",  32'(bus.p0_rdata),  32'(e_rdata[0]));
    check("p1_rdata",  32'(bus.p1_rdata),  32'(e_rdata[1]));
    check("busy",      32'(bus.busy),      32'(e_busy));
    check("mem_rw",    32'(bus.mem_rw),    32'(e_rw));
    check("mem_oe",    32'(bus.mem_wdata_oe), 32'(e_oe));
    if (chk_addr) check("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    if (e_oe)     check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    if (prev_rw_low) check("rw_consec_low", 32'(bus.mem_rw), 32'd1);
    prev_rw_low = !bus.mem_rw;
    if (!bus.mem_rw) rw_low_cnt++;
    if (bus.p0_err || bus.p1_err) err_cnt++;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge
  task automatic cycle();
    model_edge();
    @(posedge ph2); #1;
    compare_all();
    @(negedge ph2);
  endtask

  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [15:0] a, input logic [7:0] d);
    if (p) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge ph2); #1;
    compare_all();
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    @(negedge ph2);
    reset = 1'b1;
  endtask

  // Single access from one port: wait for grant, then run through RESP close
  task automatic issue(input bit p, input bit we, input logic [15:0] a, input logic [7:0] d);
    bit got = 1'b0;
    set_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (p ? bus.p1_gnt : bus.p0_gnt) begin got = 1'b1; break; end
    end
    check("gnt_wait", 32'(got), 32'd1);
    set_port(p, 1'b0, we, a, d);
    cycle();
    cycle();
  endtask

  task automatic rand_port(input bit p);
    logic [15:0] a;
    logic [3:0]  pg;
    int unsigned sel = $urandom_range(0, 2);
    pg = (sel == 0) ? RAM_PAGE : ((sel == 1) ? 4'hF : 4'h5);
    a  = {pg, 8'h00, 4'($urandom_range(0, 15))};
    set_port(p, $urandom_range(0, 99) < 55, $urandom_range(0, 2) == 0, a, 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned run, p0g, p1g;
    bit prev_p1, got;
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    bus.p1_lock = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    @(negedge ph2);
    do_reset();

    // ROM read
    rw_low_cnt = 0;
    issue(1'b0, 1'b0, 16'hF123, 8'h00);
    check("rom_rd", 32'(bus.p0_rdata), 32'h3C);
    check("rom_rw_low", rw_low_cnt, 0);

    // RAM write by p1, read back by p0
    rw_low_cnt = 0;
    issue(1'b1, 1'b1, 16'h0042, 8'hA5);
    issue(1'b0, 1'b0, 16'h0042, 8'h00);
    check("ram_rd", 32'(bus.p0_rdata), 32'hA5);
    check("ram_rw_low", rw_low_cnt, 1);

    // Write outside RAM page is dropped
    rw_low_cnt = 0; err_cnt = 0;
    issue(1'b0, 1'b1, 16'h5000, 8'h11);
    issue(1'b0, 1'b0, 16'h5000, 8'h00);
    check("bad_wr_rd", 32'(bus.p0_rdata), 32'h00);
    check("bad_wr_rw_low", rw_low_cnt, 0);
    check("bad_wr_err", err_cnt, 1);

    // Reset asserted mid-cycle during a write ACCESS
    set_port(1'b0, 1'b1, 1'b1, 16'h0077, 8'hC3);
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (bus.p0_gnt) begin got = 1'b1; break; end
    end
    check("mid_gnt_wait", 32'(got), 32'd1);
    check("mid_rw_before", 32'(bus.mem_rw), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rw_async", 32'(bus.mem_rw), 32'd1);
    check("mid_oe_async", 32'(bus.mem_wdata_oe), 32'd0);
    check("mid_gnt_async", 32'(bus.p0_gnt), 32'd0);
    check("mid_busy_async", 32'(bus.busy), 32'd0);
    if (m_txn) begin rwr[m_addr] = m_old_wr; rmem[m_addr] = m_old_val; end
    model_reset();
    @(posedge ph2); #1;
    compare_all();
    @(negedge ph2);
    reset = 1'b1;
    cycle();
    check("mid_regrant", 32'(bus.p0_gnt), 32'd1);
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    cycle();
    cycle();
    issue(1'b0, 1'b0, 16'h0077, 8'h00);
    check("mid_rd", 32'(bus.p0_rdata), 32'hC3);

    // Both reading continuously from reset: strict alternation starting with p0
    @(negedge ph2);
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 16'hF001, 8'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0003, 8'h0);
    prev_p1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.p0_gnt || bus.p1_gnt) begin
        check("rr_order", 32'(bus.p1_gnt), 32'(!prev_p1));
        prev_p1 = bus.p1_gnt;
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    cycle(); cycle(); cycle();

    // Burst lock: capped run while p0 waits, uncapped when p0 is quiet
    do_reset();
    bus.p1_lock = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 16'hF002, 8'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0004, 8'h0);
    run = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.p1_gnt) run++;
      if (bus.p0_gnt) begin got = 1'b1; break; end
    end
    check("lock_p0_seen", 32'(got), 32'd1);
    check("lock_run", run, LOCK_MAX);
    for (int i = 0; i < 6; i++) cycle();
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    p0g = 0; p1g = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.p0_gnt) p0g++;
      if (bus.p1_gnt) p1g++;
    end
    check("nocap_p0", p0g, 0);
    check("nocap_p1", 32'(p1g >= 19), 32'd1);
    bus.p1_lock = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    cycle(); cycle(); cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!e_gnt[0]) rand_port(1'b0);
      if (!e_gnt[1]) rand_port(1'b1);
      if ($urandom_range(0, 31) == 0) bus.p1_lock = !bus.p1_lock;
      cycle();
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    cycle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port memory arbiter that shares the single byte-wide development memory bus (16-bit address, 8-bit data, `rw` = 1 read / 0 write) between the CPU port (p0) and a secondary master such as a DMA or boot loader (p1). It serialises accesses into a fixed two-cycle ACCESS/RESP sequence and parks the bus in a harmless read state when idle. Because the memory writes on every clock edge while `rw` = 0, the arbiter is the only block allowed to drive `mem_rw` low.

## Interface
- `RAM_PAGE`, 4'h0: `addr[15:12]` value of the writable RAM page. Writes elsewhere are rejected.
- `LOCK_MAX`, 8: maximum consecutive p1 grants under `p1_lock` while p0 is requesting (1..15).
- `ph2`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  access request; held with addr/we/wdata stable through the cycle in which gnt is high.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  16  byte address.
- `p0_wdata`, `p1_wdata`  in  8  write data.
- `p1_lock`  in  1  p1 requests back-to-back ownership (burst).
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request accepted this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: read data valid.
- `p0_rdata`, `p1_rdata`  out  8  read data; holds until that port's next rvalid.
- `p0_err`, `p1_err`  out  1  one-cycle pulse: write outside `RAM_PAGE` was dropped.
- `busy`  out  1  state != IDLE.
- `mem_addr`  out  16  memory address.
- `mem_rw`  out  1  1 = read, 0 = write.
- `mem_wdata`  out  8  write data to the bus driver.
- `mem_wdata_oe`  out  1  enable for the arbiter's drive onto the shared data bus.
- `mem_rdata`  in  8  data bus as seen by the arbiter.

## Operation
- States:
  - IDLE: bus parked.
  - ACCESS: address/command on the bus; memory samples at the closing edge.
  - RESP: read data present on `mem_rdata`; bus turnaround.
- Arbitration is evaluated at the closing edge of IDLE or RESP:
  - If any `req` is high, go to ACCESS. Latch the winner's addr/we/wdata into internal registers; `mem_*` are driven only from these registers.
  - Otherwise go to IDLE.
- Policy:
  - Round-robin on `last_owner` (reset = p1, so p0 wins the first tie).
  - Exception: if `last_owner` = p1, `p1_lock` = 1 and `p1_req` = 1, p1 wins again, unless p0 is requesting and `lock_cnt` = `LOCK_MAX`.
  - `lock_cnt` counts consecutive p1 grants and clears on any p0 grant.
- ACCESS, read: `mem_rw` = 1, `mem_wdata_oe` = 0.
- ACCESS, write with `addr[15:12]` = `RAM_PAGE`: `mem_rw` = 0, `mem_wdata_oe` = 1, `mem_wdata` = latched wdata.
- ACCESS, write to any other page: `mem_rw` stays 1 (converted to a dummy read), and the owner's `err` pulses in the RESP cycle.
- `gnt` for the owner is high for the whole ACCESS cycle and is decoded from registers only; there is no combinational path from `req` to `gnt`.
- RESP: `mem_rw` = 1, `mem_wdata_oe` = 0. For reads, `mem_rdata` is captured at the closing edge into the owner's `rdata`, with `rvalid` high the following cycle.
- IDLE: `mem_addr` = 16'h0000, `mem_rw` = 1, `mem_wdata_oe` = 0.
- Reads outside RAM/ROM return the memory's 8'h00; the arbiter does not decode reads.

## Timing
- Reset assertion takes effect immediately, without waiting for a clock edge. All of the following hold until the first edge after release:
  - state IDLE, `mem_rw` = 1, `mem_wdata_oe` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - all gnt/rvalid/err = 0, both rdata = 8'h00, `busy` = 0
  - `last_owner` = p1, `lock_cnt` = 0
- A transaction in flight when reset asserts is dropped: no rvalid or err is produced. A write aborted during ACCESS is not guaranteed to land; the requester reissues.
- Read latency: `req` high before edge E0, then `gnt` in cycle E0..E1, RESP in E1..E2, `rvalid`/`rdata` in E2..E3.
- Write completes at E1; `gnt` is the only acknowledgement.
- Throughput is one access per 2 cycles. Back-to-back: `rvalid` of access k coincides with `gnt` of access k+1.
- `mem_rw` = 0 for exactly one cycle per legal write, and never in two consecutive cycles.
- `mem_wdata_oe` equals `~mem_rw`.
- A requester that drops `req` before its `gnt` cycle is simply not served; no error is flagged.

## Test plan
- After reset, ROM preloaded with 0xF123 = 8'h3C; p0 reads 16'hF123 → `p0_gnt` at E0, `p0_rvalid` with `p0_rdata` = 8'h3C at E2, `mem_rw` never 0.
- p1 writes 8'hA5 to 16'h0042, then p0 reads 16'h0042 → `mem_rw` = 0 for exactly one cycle with `mem_addr` = 0042 and `mem_wdata` = A5; p0 reads back 8'hA5.
- p0 writes 8'h11 to 16'h5000 → `p0_err` pulse in RESP, `mem_rw` stays 1 throughout, and the following read of 16'h5000 returns 8'h00.
- p0 and p1 both request reads continuously from reset → grants ordered p0, p1, p0, p1…, one every 2 cycles, each `rvalid` routed to the correct port only.
- `p1_lock` = 1, p1 and p0 both requesting continuously → 8 consecutive p1 grants, then one p0 grant, then p1 again; with `p0_req` = 0, p1 keeps ownership with no cap.
- Assert `reset` mid-cycle during a write ACCESS → `mem_rw` returns to 1 and `mem_wdata_oe` to 0 immediately. After release, no stale rvalid/err appears and the held request is re-granted at the first evaluation edge.
